led_chaser: RTL and testbench
=============================

// Module: led_chaser
// PURPOSE
//  Parametrised LED chaser for the board LED bank. Steps a lit position across NUM_LEDS
//  outputs at a programmable rate, in one of four switch-selected modes (forward,
//  reverse, bounce, fill bar), with run/pause. Sits between the slide switches and the LED pins.
// PARAMETERS
//  NUM_LEDS    8        number of LED outputs; legal range 2..32
//  PERIOD      2**23    clk cycles per step; >= 2 (2**23 ~ 0.168 s at 50 MHz)
//  SYNC_STAGES 2        synchroniser depth on switch inputs; >= 2
// PORTS
//  clk   in   1                  50 MHz system clock
//  rst   in   1                  synchronous reset, active-high
//  mode  in   2                  async slide switches: 0 FWD, 1 REV, 2 BOUNCE, 3 FILL
//  run   in   1                  async slide switch: 1 = advance, 0 = pause (hold state)
//  led   out  NUM_LEDS           LED drive, 1 = lit
//  pos   out  $clog2(NUM_LEDS)   current position index
//  tick  out  1                  one-cycle pulse on each step
// BEHAVIOUR
//  - All state updates on posedge clk; rst sampled on posedge only. rst wins over all else.
//  - Reset: pos=0, dir=UP, prescaler=0, tick=0, synchronisers=0 (mode_s=FWD, run_s=0), led=1 at bit 0.
//  - mode/run pass through SYNC_STAGES flops -> mode_s, run_s; edge affects prescaler
//    SYNC_STAGES cycles later. No debounce (step period >> bounce time).
//  - Prescaler cnt: if run_s, cnt = (cnt==PERIOD-1) ? 0 : cnt+1; else hold.
//    tick registered: asserted the cycle after cnt==PERIOD-1 && run_s; pos updates in same cycle as tick.
//  - Mode sampled at step time only (mode_s in the cycle of the wrap); mid-period changes never glitch pos.
//  - Step rules (N = NUM_LEDS):
//     FWD:    pos = (pos==N-1) ? 0 : pos+1; dir=UP
//     REV:    pos = (pos==0) ? N-1 : pos-1; dir=DOWN
//     BOUNCE: dir UP:   pos==N-1 -> dir=DOWN, pos=N-2; else pos+1
//             dir DOWN: pos==0   -> dir=UP,   pos=1;   else pos-1
//             (turnaround in one step; ends never shown twice; N=2 alternates 0,1,0,1)
//             entering BOUNCE keeps current dir; at an end with outward dir, turnaround rule applies
//     FILL:   pos as FWD; dir=UP
//  - led decode (combinational from registered pos/mode_s): FWD/REV/BOUNCE one-hot led[pos];
//    FILL led[i]=1 for all i<=pos (full bar at N-1, then wraps to single LED 0).
//  - pos width $clog2(N); never holds a value >= N (no-wrap arithmetic on non-power-of-2 N).
//  - Pause (run_s=0): cnt, pos, dir frozen; led keeps showing; tick held 0. Resume continues from frozen cnt.
//  - rst mid-period: next cycle is the reset state; first tick PERIOD cycles after run_s rises.
// CONFIGURATION
//  LED_CHASER_TRAIL_EN defined: extra reg prev = pos before last step (reset 0); in one-hot modes
//    led[prev] additionally lit at 25% duty from free-running 2-bit pwm counter (on when pwm==0,
//    reset 0), only while prev != pos; FILL mode ignores trail. Not defined: led is exactly the decode above; no prev/pwm logic.
// STRUCTURE
//  - led_chaser_pkg: typedef enum logic [1:0] {MODE_FWD, MODE_REV, MODE_BOUNCE, MODE_FILL} mode_t;
//    typedef enum logic {DIR_UP, DIR_DOWN} dir_t.
//  - Sub-module sync_ff (WIDTH, STAGES): flop-chain synchroniser, instantiated once on {run, mode}.
//  - Prescaler, step FSM and led decode stay in led_chaser.
// TESTING  (NUM_LEDS=8, PERIOD=4, SYNC_STAGES=2 unless stated)
//  1. rst 3 cycles, mode=0 run=1 -> led=8'h01 at reset; ticks every 4 cycles; pos 0..7,0; led 01,02..80,01.
//  2. mode=2 -> pos 0,1..7,6,5..0,1; no end repeated; tick spacing constant 4 cycles.
//  3. mode=3 -> led 01,03,07..FF, then 01; mode=1 from pos 0 -> pos 7,6,...; led one-hot.
//  4. run=0 for 20 cycles mid-period -> no tick, pos/led frozen; run=1 -> next tick after remaining count.
//  5. rst asserted at pos=5, BOUNCE dir=DOWN -> next cycle pos=0, dir=UP, led=01, tick=0.
//  6. NUM_LEDS=5 BOUNCE -> 0,1,2,3,4,3,2,1,0; TRAIL_EN build FWD -> led[pos-1] lit 1 cycle in 4.

Source files
------------

// File: rtl/led_chaser_pkg.sv
// ============================================================================
//  Module      : led_chaser_pkg
//  Description : Shared mode/direction types for the LED chaser.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_chaser_pkg;

  typedef enum logic [1:0] {
    MODE_FWD    = 2'd0,
    MODE_REV    = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_FILL   = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Synchronised switch bundle is {run, mode}
  localparam int SYNC_W = 3;

endpackage

`default_nettype wire

// File: rtl/sync_ff.sv
// ============================================================================
//  Module      : sync_ff
//  Description : Flop-chain synchroniser for asynchronous switch inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/led_chaser.sv
// ============================================================================
//  Module      : led_chaser
//  Description : Programmable-rate LED chaser (forward/reverse/bounce/fill)
//                with run/pause. Optional trail LED when LED_CHASER_TRAIL_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_chaser
  import led_chaser_pkg::*;
#(
  parameter int NUM_LEDS    = 8,
  parameter int PERIOD      = 2**23,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  mode,
  input  logic                        run,
  output logic [NUM_LEDS-1:0]         led,
  output logic [$clog2(NUM_LEDS)-1:0] pos,
  output logic                        tick
);

  localparam int c_POS_W = $clog2(NUM_LEDS);
  localparam int c_CNT_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [c_POS_W-1:0] c_POS_ONE  = c_POS_W'(1);
  localparam logic [c_POS_W-1:0] c_POS_LAST = c_POS_W'(NUM_LEDS - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(PERIOD - 1);
  localparam logic [NUM_LEDS-1:0] c_LED_ONE = NUM_LEDS'(1);

  logic [SYNC_W-1:0]  w_sync_q;
  logic               w_run_s;
  mode_t              w_mode_s;
  logic               w_step;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_POS_W-1:0] r_pos;
  logic [c_POS_W-1:0] w_pos_nxt;
  dir_t               r_dir;
  dir_t               w_dir_nxt;
  logic               r_tick;
  logic [NUM_LEDS-1:0] w_led;

  sync_ff #(
    .WIDTH  (SYNC_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({run, mode}),
    .q   (w_sync_q)
  );

  assign w_run_s  = w_sync_q[2];
  assign w_mode_s = mode_t'(w_sync_q[1:0]);
  assign w_step   = w_run_s && (r_cnt == c_CNT_MAX);

  // Next position is evaluated only with the mode seen in the wrap cycle
  always_comb begin
    w_pos_nxt = r_pos;
    w_dir_nxt = r_dir;
    case (w_mode_s)
      MODE_REV: begin
        w_pos_nxt = (r_pos == '0) ? c_POS_LAST : r_pos - c_POS_ONE;
        w_dir_nxt = DIR_DOWN;
      end
      MODE_BOUNCE: begin
        if (r_dir == DIR_UP) begin
          if (r_pos == c_POS_LAST) begin
            w_pos_nxt = c_POS_LAST - c_POS_ONE;
            w_dir_nxt = DIR_DOWN;
          end else begin
            w_pos_nxt = r_pos + c_POS_ONE;
          end
        end else begin
          if (r_pos == '0) begin
            w_pos_nxt = c_POS_ONE;
            w_dir_nxt = DIR_UP;
          end else begin
            w_pos_nxt = r_pos - c_POS_ONE;
          end
        end
      end
      default: begin
        w_pos_nxt = (r_pos == c_POS_LAST) ? '0 : r_pos + c_POS_ONE;
        w_dir_nxt = DIR_UP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_pos  <= '0;
      r_dir  <= DIR_UP;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_step;
      if (w_run_s) begin
        r_cnt <= (r_cnt == c_CNT_MAX) ? '0 : r_cnt + c_CNT_ONE;
      end
      if (w_step) begin
        r_pos <= w_pos_nxt;
        r_dir <= w_dir_nxt;
      end
    end
  end

  always_comb begin
    w_led = '0;
    if (w_mode_s == MODE_FILL) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        w_led[i] = (i <= int'(r_pos));
      end
    end else begin
      w_led = c_LED_ONE << r_pos;
    end
  end

`ifdef LED_CHASER_TRAIL_EN
  logic [c_POS_W-1:0] r_prev;
  logic [1:0]         r_pwm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= '0;
      r_pwm  <= 2'd0;
    end else begin
      r_pwm <= r_pwm + 2'd1;
      if (w_step) begin
        r_prev <= r_pos;
      end
    end
  end

  // Dim trail: previous position lit one cycle in four, one-hot modes only
  assign led = w_led | (((r_pwm == 2'd0) && (r_prev != r_pos) && (w_mode_s != MODE_FILL))
                        ? (c_LED_ONE << r_prev) : '0);
`else
  assign led = w_led;
`endif

  assign pos  = r_pos;
  assign tick = r_tick;

endmodule

`default_nettype wire

// File: tb/tb_led_chaser.sv
// ============================================================================
//  Module      : tb_led_chaser
//  Description : Directed self-checking bench for led_chaser (8 and 5 LEDs).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_chaser;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic       run;
  logic [7:0] led;
  logic [2:0] pos;
  logic       tick;

  logic       rst5;
  logic [1:0] mode5;
  logic       run5;
  logic [4:0] led5;
  logic [2:0] pos5;
  logic       tick5;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  led_chaser #(.NUM_LEDS(8), .PERIOD(4), .SYNC_STAGES(2)) u_dut (
    .clk (clk), .rst (rst), .mode (mode), .run (run),
    .led (led), .pos (pos), .tick (tick)
  );

  led_chaser #(.NUM_LEDS(5), .PERIOD(4), .SYNC_STAGES(2)) u_dut5 (
    .clk (clk), .rst (rst5), .mode (mode5), .run (run5),
    .led (led5), .pos (pos5), .tick (tick5)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Waits for a tick on the selected instance, returns edges elapsed
  task automatic wait_tick(input bit sel5, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (((sel5 ? tick5 : tick) !== 1'b1) && n < 40);
    if ((sel5 ? tick5 : tick) !== 1'b1) check_val("tick_timeout", 32'd0, 32'd1);
  endtask

  // In a trail build the dim LED may appear; keep only the lit-position bit
  function automatic logic [31:0] view(input logic [31:0] l, input int p);
`ifdef LED_CHASER_TRAIL_EN
    return l & (32'd1 << p);
`else
    return l + 32'd0 * p;
`endif
  endfunction

  initial begin
    int n;
    int exp_b[15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    int exp_fp[7] = '{2, 3, 4, 5, 6, 7, 0};
    logic [7:0] exp_fl[7] = '{8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h01};
    int exp_r[3]  = '{7, 6, 5};
    int exp_5[9]  = '{1, 2, 3, 4, 3, 2, 1, 0, 1};
    int frozen_bad;

    rst = 1'b1; mode = 2'd0; run = 1'b1;
    rst5 = 1'b1; mode5 = 2'd2; run5 = 1'b1;
    repeat (3) cyc();
    check_val("rst_led", 32'(led), 32'h01);
    check_val("rst_pos", 32'(pos), 32'd0);
    check_val("rst_tick", 32'(tick), 32'd0);

    // Forward sweep
    rst = 1'b0;
    wait_tick(1'b0, n);
    check_val("first_tick_latency", n, 6);
    check_val("fwd_pos", 32'(pos), 32'd1);
    check_val("fwd_led", view(32'(led), 1), 32'h02);
    for (int k = 2; k <= 8; k++) begin
      wait_tick(1'b0, n);
      check_val("fwd_spacing", n, 4);
      check_val("fwd_pos", 32'(pos), 32'(k % 8));
      check_val("fwd_led", view(32'(led), k % 8), 32'd1 << (k % 8));
    end

    // Bounce from pos 0, direction up
    mode = 2'd2;
    for (int k = 0; k < 15; k++) begin
      wait_tick(1'b0, n);
      check_val("bounce_spacing", n, 4);
      check_val("bounce_pos", 32'(pos), 32'(exp_b[k]));
      check_val("bounce_led", view(32'(led), exp_b[k]), 32'd1 << exp_b[k]);
    end

    // Fill bar
    mode = 2'd3;
    for (int k = 0; k < 7; k++) begin
      wait_tick(1'b0, n);
      check_val("fill_pos", 32'(pos), 32'(exp_fp[k]));
      check_val("fill_led", 32'(led), 32'(exp_fl[k]));
    end

    // Reverse from pos 0
    mode = 2'd1;
    for (int k = 0; k < 3; k++) begin
      wait_tick(1'b0, n);
      check_val("rev_pos", 32'(pos), 32'(exp_r[k]));
      check_val("rev_led", view(32'(led), exp_r[k]), 32'd1 << exp_r[k]);
    end

    // Pause right after a step: counter freezes at 2 (two in-flight increments)
    run = 1'b0;
    frozen_bad = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (tick !== 1'b0 || pos !== 3'd5 || view(32'(led), 5) !== 32'h20) frozen_bad++;
    end
    check_val("pause_frozen_cycles_bad", frozen_bad, 0);
    run = 1'b1;
    wait_tick(1'b0, n);
    check_val("resume_latency", n, 4);
    check_val("resume_pos", 32'(pos), 32'd4);

    // Bounce from pos 4 heading down until pos 5 heading down
    mode = 2'd2;
    for (int k = 0; k < 13; k++) wait_tick(1'b0, n);
    check_val("bounce_down_pos", 32'(pos), 32'd5);
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    check_val("midrst_pos", 32'(pos), 32'd0);
    check_val("midrst_led", 32'(led), 32'h01);
    check_val("midrst_tick", 32'(tick), 32'd0);
    rst = 1'b0;
    wait_tick(1'b0, n);
    check_val("midrst_first_tick", n, 6);
    check_val("midrst_dir_up_pos", 32'(pos), 32'd1);

    // Five-LED bounce
    rst5 = 1'b0;
    for (int k = 0; k < 9; k++) begin
      wait_tick(1'b1, n);
      check_val("n5_pos", 32'(pos5), 32'(exp_5[k]));
      check_val("n5_led", view(32'(led5), exp_5[k]), 32'd1 << exp_5[k]);
    end

`ifdef LED_CHASER_TRAIL_EN
    begin
      int n_trail;
      int n_plain;
      int p;
      mode = 2'd0;
      wait_tick(1'b0, n);
      wait_tick(1'b0, n);
      wait_tick(1'b0, n);
      p = int'(pos);
      n_trail = 0;
      n_plain = 0;
      for (int k = 0; k < 4; k++) begin
        if (k > 0) cyc();
        if (led === 8'((1 << p) | (1 << ((p + 7) % 8)))) n_trail++;
        else if (led === 8'(1 << p)) n_plain++;
      end
      check_val("trail_on_cycles", n_trail, 1);
      check_val("trail_off_cycles", n_plain, 3);
    end
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
